sys_run_sequencer: RTL and testbench

Run controller for the 4x4 systolic array. It decodes control-register writes from the host ibus, then sequences each tile: clears the PE accumulators, streams the A0/A1/B0/B1 buffer read addresses, generates the per-lane skew enables, and flushes and drains results. It sits between the ibus decoder and the array/iobuf. It owns the 0xFFF0–0xFFF3 register window.

---
 rtl/sys_ctrl_pkg.sv | 34 +++
 rtl/sys_skew_sreg.sv | 29 ++
 rtl/sys_run_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_sys_run_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared constants and types for the systolic-array run controller.
// Holds the register-window addresses, CTRL bit positions, the
// sequencer state enum and the STATUS register layout.
package sys_ctrl_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned DRAIN_IDX_W = 2;

    localparam logic [DATA_W-1:0] SYS_START_ADR = 16'hFFF0;
    localparam logic [DATA_W-1:0] SYS_MAX_CNTR  = 16'hFFF1;
    localparam logic [DATA_W-1:0] SYS_RUN_CNTR  = 16'hFFF2;
    localparam logic [DATA_W-1:0] SYS_STATUS    = 16'hFFF3;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_ABORT_BIT = 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN,
        NEXT
    } run_state_e;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic [5:0]       rsvd;
        logic [CNT_W-1:0] tiles_done;
    } status_t;

endpackage

// File: rtl/sys_skew_sreg.sv
// Lane skew shift register: bit 0 follows din one cycle later, and each
// higher bit repeats the bit below it one cycle later.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous clear of every stage
//   din       lane-0 valid for the next cycle
//   q         skewed lane-valid vector (N bits)
module sys_skew_sreg #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         din,
    output logic [N-1:0] q
);

    // Top bit of the concatenation falls off the end each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else begin
            q <= N'({q, din});
        end
    end

endmodule

// File: rtl/sys_run_sequencer.sv
// Run controller for the NxN systolic array. Decodes writes to the
// 0xFFF0-0xFFF3 window, then for each tile clears the PE accumulators,
// streams the common A/B buffer read address, flushes the skewed lanes and
// drains the result rows.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wen, ibus_wadr/wdata     host register write
//   ren, ibus_radr           host register read
//   ctrl_rdata, ctrl_rsel    read data / valid, one cycle after ren
//   buf_ren, buf_radr        buffer read enable and address
//   lane_en                  skewed per-lane valid
//   pe_clr                   one-cycle accumulator clear
//   drain, drain_idx         result drain phase and row index
//   busy, done               run in progress / sticky completion
module sys_run_sequencer
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned ADR_W = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wen,
    input  logic [DATA_W-1:0]      ibus_wadr,
    input  logic [DATA_W-1:0]      ibus_wdata,
    input  logic                   ren,
    input  logic [DATA_W-1:0]      ibus_radr,
    output logic [DATA_W-1:0]      ctrl_rdata,
    output logic                   ctrl_rsel,
    output logic                   buf_ren,
    output logic [ADR_W-1:0]       buf_radr,
    output logic [N-1:0]           lane_en,
    output logic                   pe_clr,
    output logic                   drain,
    output logic [DRAIN_IDX_W-1:0] drain_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned FLUSH_LEN = 2 * N - 1;
    localparam int unsigned DRAIN_LEN = N;

    run_state_e             state;
    run_state_e             state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       max_cntr;
    logic [CNT_W-1:0]       run_cntr;
    logic [CNT_W-1:0]       tiles_done;

    logic                   wr_ctrl_c;
    logic                   abort_c;
    logic                   start_c;
    logic                   last_tile_c;
    logic                   idle_c;

    logic                   busy_d;
    logic                   pe_clr_d;
    logic                   buf_ren_d;
    logic                   lane0_d;
    logic                   drain_d;
    logic [DRAIN_IDX_W-1:0] drain_idx_d;
    logic                   rsel_d;
    logic [DATA_W-1:0]      rdata_d;
    status_t                status_c;

    logic                   unused_wdata;
    assign unused_wdata = &{1'b0, ibus_wdata[DATA_W-1:CNT_W]};

    // Write-side decode; abort outranks start, start only from IDLE.
    assign idle_c      = (state == IDLE);
    assign wr_ctrl_c   = wen && (ibus_wadr == SYS_START_ADR);
    assign abort_c     = wr_ctrl_c && ibus_wdata[CTRL_ABORT_BIT];
    assign start_c     = wr_ctrl_c && ibus_wdata[CTRL_START_BIT] && !abort_c && idle_c;
    assign last_tile_c = (tiles_done == run_cntr);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; each phase length is measured by cnt, which
    // restarts at zero on every state change.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_c) state_next = CLEAR;
            CLEAR:   state_next = FEED;
            FEED:    if (cnt == max_cntr) state_next = FLUSH;
            FLUSH:   if (cnt == CNT_W'(FLUSH_LEN - 1)) state_next = DRAIN;
            DRAIN:   if (cnt == CNT_W'(DRAIN_LEN - 1)) state_next = NEXT;
            NEXT:    state_next = last_tile_c ? IDLE : CLEAR;
            default: state_next = IDLE;
        endcase
        if (abort_c) begin
            state_next = IDLE;
        end
    end

    // Output decode from the next state, so every strobe is a flop that
    // lines up with the state it belongs to.
    always_comb begin
        cnt_d       = '0;
        busy_d      = 1'b0;
        pe_clr_d    = 1'b0;
        buf_ren_d   = 1'b0;
        lane0_d     = 1'b0;
        drain_d     = 1'b0;
        drain_idx_d = '0;
        rsel_d      = 1'b0;
        rdata_d     = '0;

        if (state_next != IDLE && state_next == state) begin
            cnt_d = cnt + 8'd1;
        end
        busy_d    = (state_next != IDLE);
        pe_clr_d  = (state_next == CLEAR);
        buf_ren_d = (state_next == FEED);
        lane0_d   = (state_next == FEED);
        drain_d   = (state_next == DRAIN);
        if (drain_d) begin
            drain_idx_d = DRAIN_IDX_W'(cnt_d);
        end

        status_c.busy       = busy;
        status_c.done       = done;
        status_c.rsvd       = '0;
        status_c.tiles_done = tiles_done;
        if (ren) begin
            rsel_d = 1'b1;
            case (ibus_radr)
                SYS_START_ADR: rdata_d = '0;
                SYS_MAX_CNTR:  rdata_d = {8'h00, max_cntr};
                SYS_RUN_CNTR:  rdata_d = {8'h00, run_cntr};
                SYS_STATUS:    rdata_d = status_c;
                default: begin
                    rsel_d  = 1'b0;
                    rdata_d = '0;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            max_cntr   <= '0;
            run_cntr   <= '0;
            tiles_done <= '0;
            buf_radr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pe_clr     <= 1'b0;
            buf_ren    <= 1'b0;
            drain      <= 1'b0;
            drain_idx  <= '0;
            ctrl_rsel  <= 1'b0;
            ctrl_rdata <= '0;
        end else begin
            cnt        <= cnt_d;
            busy       <= busy_d;
            pe_clr     <= pe_clr_d;
            buf_ren    <= buf_ren_d;
            drain      <= drain_d;
            drain_idx  <= drain_idx_d;
            ctrl_rsel  <= rsel_d;
            ctrl_rdata <= rdata_d;

            if (wen && idle_c && ibus_wadr == SYS_MAX_CNTR) begin
                max_cntr <= ibus_wdata[CNT_W-1:0];
            end
            if (wen && idle_c && ibus_wadr == SYS_RUN_CNTR) begin
                run_cntr <= ibus_wdata[CNT_W-1:0];
            end

            // Address keeps running across tiles; it only restarts on start.
            if (start_c) begin
                buf_radr <= '0;
            end else if (state == FEED) begin
                buf_radr <= buf_radr + ADR_W'(1);
            end

            // The final NEXT leaves tiles_done at R, so STATUS reads back
            // the programmed run count once the run completes.
            if (start_c) begin
                tiles_done <= '0;
                done       <= 1'b0;
            end else if (state == NEXT && !abort_c) begin
                if (last_tile_c) begin
                    done <= 1'b1;
                end else begin
                    tiles_done <= tiles_done + 8'd1;
                end
            end
        end
    end

    sys_skew_sreg #(
        .N (N)
    ) u_skew (
        .clk (clk),
        .rst (rst),
        .clr (abort_c),
        .din (lane0_d),
        .q   (lane_en)
    );

endmodule

// File: tb/tb_sys_run_sequencer.sv
// Self-checking bench for sys_run_sequencer: directed scenarios plus
// randomized runs compared cycle by cycle against a tile-timeline model.
module tb_sys_run_sequencer;

    localparam int N     = 4;
    localparam int ADR_W = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [15:0] ibus_wadr;
    logic [15:0] ibus_wdata;
    logic        ren;
    logic [15:0] ibus_radr;
    logic [15:0] ctrl_rdata;
    logic        ctrl_rsel;
    logic        buf_ren;
    logic [ADR_W-1:0] buf_radr;
    logic [N-1:0] lane_en;
    logic        pe_clr;
    logic        drain;
    logic [1:0]  drain_idx;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sys_run_sequencer #(.N(N), .ADR_W(ADR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wen        (wen),
        .ibus_wadr  (ibus_wadr),
        .ibus_wdata (ibus_wdata),
        .ren        (ren),
        .ibus_radr  (ibus_radr),
        .ctrl_rdata (ctrl_rdata),
        .ctrl_rsel  (ctrl_rsel),
        .buf_ren    (buf_ren),
        .buf_radr   (buf_radr),
        .lane_en    (lane_en),
        .pe_clr     (pe_clr),
        .drain      (drain),
        .drain_idx  (drain_idx),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] obs_vec();
        return {busy, pe_clr, buf_ren, buf_radr, lane_en, drain, drain_idx, done};
    endfunction

    function automatic logic [19:0] pack(input logic b, input logic c, input logic rn,
                                         input int radr, input logic [3:0] lane,
                                         input logic dr, input int idx, input logic dn);
        return {b, c, rn, 9'(radr % 512), lane, dr, 2'(idx), dn};
    endfunction

    // Feed cycles that occurred among the first j cycles of a run.
    function automatic int feeds(input int m, input int r, input int j);
        int pl, tot, t, rem, f;
        pl  = m + 3 * N + 2;
        tot = (r + 1) * pl;
        if (j > tot) j = tot;
        if (j < 0) j = 0;
        t   = j / pl;
        rem = j % pl;
        f   = rem - 1;
        if (f < 0) f = 0;
        if (f > m + 1) f = m + 1;
        return t * (m + 1) + f;
    endfunction

    // Expected outputs in cycle k after the start write was captured.
    // Tile layout: clear (1), feed (m+1), flush (2N-1), drain (N), next (1).
    function automatic logic [19:0] model(input int m, input int r, input int k);
        int pl, tot, p, idx;
        logic [3:0] lane;
        logic dr;
        pl  = m + 3 * N + 2;
        tot = (r + 1) * pl;
        if (k > tot) return pack(1'b0, 1'b0, 1'b0, feeds(m, r, k - 1), 4'b0, 1'b0, 0, 1'b1);
        p = (k - 1) % pl;
        lane = '0;
        for (int i = 0; i < N; i++) lane[i] = (p - i >= 1) && (p - i <= m + 1);
        dr  = (p >= m + 2 * N + 1) && (p <= m + 3 * N);
        idx = dr ? p - (m + 2 * N + 1) : 0;
        return pack(1'b1, p == 0, (p >= 1) && (p <= m + 1), feeds(m, r, k - 1), lane, dr, idx, 1'b0);
    endfunction

    task automatic wr(input logic [15:0] adr, input logic [15:0] data);
        @(negedge clk);
        wen = 1'b1; ibus_wadr = adr; ibus_wdata = data;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] adr, input logic exp_sel, input logic [15:0] exp_data);
        @(negedge clk);
        ren = 1'b1; ibus_radr = adr;
        @(negedge clk);
        ren = 1'b0;
        check($sformatf("rd %h sel/data", adr), {15'd0, ctrl_rsel, ctrl_rdata}, {15'd0, exp_sel, exp_data});
        @(negedge clk);
        check($sformatf("rd %h sel drop", adr), {31'd0, ctrl_rsel}, 32'd0);
    endtask

    // mode 0: no extra writes; 1: directed ignored writes; 2: random ignored writes.
    task automatic run_check(input int m, input int r, input int mode,
                             input int abort_k, input int rst_k);
        int pl, tot;
        pl  = m + 3 * N + 2;
        tot = (r + 1) * pl;
        wr(16'hFFF1, 16'(m));
        wr(16'hFFF2, 16'(r));
        @(negedge clk);
        wen = 1'b1; ibus_wadr = 16'hFFF0; ibus_wdata = 16'h0001;
        for (int k = 1; k <= tot + 1; k++) begin
            @(negedge clk);
            wen = 1'b0;
            check($sformatf("run m%0d r%0d k%0d", m, r, k), obs_vec(), model(m, r, k));
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                check("rst async", {obs_vec(), 11'd0, ctrl_rsel}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (k == abort_k) begin
                wen = 1'b1; ibus_wadr = 16'hFFF0; ibus_wdata = 16'h0002;
                @(negedge clk);
                wen = 1'b0;
                check("abort", obs_vec(), pack(1'b0, 1'b0, 1'b0, feeds(m, r, k), 4'b0, 1'b0, 0, 1'b0));
                return;
            end
            if (k <= tot && mode != 0) begin
                if (k == tot) begin
                    wen = 1'b1; ibus_wadr = 16'hFFF0; ibus_wdata = 16'h0001;
                end else if (mode == 1 && k == 5) begin
                    wen = 1'b1; ibus_wadr = 16'hFFF0; ibus_wdata = 16'h0001;
                end else if (mode == 1 && k == 20) begin
                    wen = 1'b1; ibus_wadr = 16'hFFF1; ibus_wdata = 16'h0007;
                end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
                    wen = 1'b1;
                    ibus_wadr = 16'hFFF0 + 16'($urandom_range(0, 3));
                    ibus_wdata = 16'($urandom);
                    if (ibus_wadr == 16'hFFF0) ibus_wdata = (ibus_wdata & 16'hFFFD) | 16'h0001;
                end
            end
        end
    endtask

    initial begin
        int m, r;
        rst = 1'b1; wen = 1'b0; ren = 1'b0;
        ibus_wadr = '0; ibus_wdata = '0; ibus_radr = '0;
        @(negedge clk);
        check("reset outputs", {obs_vec(), ctrl_rsel, ctrl_rdata[10:0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        rd(16'h1234, 1'b0, 16'h0000);
        rd(16'hFFF0, 1'b1, 16'h0000);

        run_check(3, 3, 0, 0, 0);
        rd(16'hFFF3, 1'b1, 16'h4003);
        rd(16'hFFF1, 1'b1, 16'h0003);
        rd(16'hFFF2, 1'b1, 16'h0003);

        run_check(0, 0, 0, 0, 0);
        rd(16'hFFF3, 1'b1, 16'h4000);

        run_check(3, 3, 1, 0, 0);
        rd(16'hFFF1, 1'b1, 16'h0003);

        run_check(3, 3, 0, 3 * N + 5 + 2, 0);
        rd(16'hFFF3, 1'b1, 16'h0001);

        run_check(3, 1, 0, 0, 13);
        rd(16'hFFF1, 1'b1, 16'h0000);
        run_check(0, 0, 0, 0, 0);

        // Read and write of the same register in one cycle returns the old value.
        wr(16'hFFF1, 16'h0005);
        @(negedge clk);
        wen = 1'b1; ibus_wadr = 16'hFFF1; ibus_wdata = 16'h0009;
        ren = 1'b1; ibus_radr = 16'hFFF1;
        @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        check("rd during wr", {15'd0, ctrl_rsel, ctrl_rdata}, {15'd0, 1'b1, 16'h0005});
        rd(16'hFFF1, 1'b1, 16'h0009);

        for (int t = 0; t < 5; t++) begin
            m = $urandom_range(0, 40);
            r = $urandom_range(0, 4);
            run_check(m, r, 2, 0, 0);
            rd(16'hFFF3, 1'b1, 16'h4000 | 16'(r));
            rd(16'hFFF1, 1'b1, 16'(m));
        end

        run_check(255, 0, 0, 0, 0);
        rd(16'hFFF3, 1'b1, 16'h4000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
